// File: rtl/request_retry_ctrl.sv
// Purpose: per-request timeout/retry controller; issues one request downstream, re-issues on timeout, reports pass/fail.
// Latency: issue one cycle after accept; done one cycle after a matching response or after the final timeout.
// Backpressure: issue stalls on issue_ready (timer frozen); done is a one-cycle pulse with no backpressure.
module request_retry_ctrl #(
  parameter int TIMEOUT_BITS = 3,
  parameter int MAX_RETRIES  = 3,
  parameter int ID_WIDTH     = 8,
  localparam int RETRY_W     = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ID_WIDTH-1:0] req_id,
  output logic                issue_valid,
  input  logic                issue_ready,
  output logic [ID_WIDTH-1:0] issue_id,
  output logic                issue_retry,
  input  logic                resp_valid,
  input  logic [ID_WIDTH-1:0] resp_id,
  output logic                done_valid,
  output logic                done_ok,
  output logic [ID_WIDTH-1:0] done_id,
  output logic [RETRY_W-1:0]  done_retries,
  output logic                busy
);

  localparam logic [RETRY_W-1:0]      RETRY_MAX = RETRY_W'(MAX_RETRIES);
  localparam logic [TIMEOUT_BITS-1:0] TIMER_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [TIMEOUT_BITS-1:0] r_timer;
  logic [RETRY_W-1:0]    r_retry;
  logic [ID_WIDTH-1:0]   r_id;
  logic                  r_ok;

  logic w_timeout;
  logic w_resp_match;
  logic w_retry_max;

  assign w_timeout    = (r_timer == TIMER_MAX);
  assign w_resp_match = resp_valid && (resp_id == r_id);
  assign w_retry_max  = (r_retry == RETRY_MAX);

  // State register; reset aborts any request in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: latched tag, retry count, timeout timer and completion status.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= '0;
      r_retry <= '0;
      r_id    <= '0;
      r_ok    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_id    <= req_id;
            r_retry <= '0;
            r_ok    <= 1'b0;
          end
        end
        S_ISSUE: begin
          // Held at zero so every WAIT period starts from a fresh count.
          r_timer <= '0;
        end
        S_WAIT: begin
          if (w_resp_match) begin
            r_ok <= 1'b1;
          end else if (w_timeout) begin
            if (!w_retry_max) begin
              r_retry <= r_retry + RETRY_W'(1);
            end
          end else begin
            // WAIT is left at the maximum, so the timer can never wrap.
            r_timer <= r_timer + TIMEOUT_BITS'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and output decode; a matching response outranks a coincident timeout.
  always_comb begin
    w_state_nxt  = r_state;
    req_ready    = 1'b0;
    issue_valid  = 1'b0;
    issue_id     = '0;
    issue_retry  = 1'b0;
    done_valid   = 1'b0;
    done_ok      = 1'b0;
    done_id      = '0;
    done_retries = '0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        req_ready = !reset;
        if (req_valid) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue_valid = 1'b1;
        issue_id    = r_id;
        issue_retry = (r_retry != '0);
        if (issue_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_resp_match) begin
          w_state_nxt = S_DONE;
        end else if (w_timeout) begin
          w_state_nxt = w_retry_max ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        done_valid   = 1'b1;
        done_ok      = r_ok;
        done_id      = r_id;
        done_retries = r_retry;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_request_retry_ctrl.sv
// Purpose: directed, table-driven bench for request_retry_ctrl (TIMEOUT_BITS=3, MAX_RETRIES=2, ID_WIDTH=8).
// Latency: expectations are cycle-exact, counted from the accept cycle.
// Backpressure: exercises issue_ready stalls; done has none.
module tb_request_retry_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_id;
  logic       issue_valid;
  logic       issue_ready;
  logic [7:0] issue_id;
  logic       issue_retry;
  logic       resp_valid;
  logic [7:0] resp_id;
  logic       done_valid;
  logic       done_ok;
  logic [7:0] done_id;
  logic [1:0] done_retries;
  logic       busy;

  request_retry_ctrl #(
    .TIMEOUT_BITS(3),
    .MAX_RETRIES (2),
    .ID_WIDTH    (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_id      (req_id),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_id    (issue_id),
    .issue_retry (issue_retry),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .done_valid  (done_valid),
    .done_ok     (done_ok),
    .done_id     (done_id),
    .done_retries(done_retries),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Event log of issue handshakes and done pulses, sampled at the falling edge.
  int iss_cyc[$];
  int iss_ret[$];
  int dn_cyc[$];
  int dn_ok[$];
  int dn_id[$];
  int dn_ret[$];

  always @(negedge clk) begin
    if (issue_valid === 1'b1 && issue_ready === 1'b1) begin
      iss_cyc.push_back(cyc);
      iss_ret.push_back(int'(issue_retry));
    end
    if (done_valid === 1'b1) begin
      dn_cyc.push_back(cyc);
      dn_ok.push_back(int'(done_ok));
      dn_id.push_back(int'(done_id));
      dn_ret.push_back(int'(done_retries));
    end
  end

  typedef struct {
    logic       rv;
    logic [7:0] rid;
    logic       ir;
    logic       sv;
    logic [7:0] sid;
    logic       e_rrdy;
    logic       e_iv;
    logic [7:0] e_iid;
    logic       e_iret;
    logic       e_dv;
    logic       e_dok;
    logic [7:0] e_did;
    logic [1:0] e_dret;
    logic       e_busy;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic rv, input logic [7:0] rid, input logic ir,
                      input logic sv, input logic [7:0] sid,
                      input logic e_rrdy, input logic e_iv, input logic [7:0] e_iid,
                      input logic e_iret, input logic e_dv, input logic e_dok,
                      input logic [7:0] e_did, input logic [1:0] e_dret, input logic e_busy);
    vec_t v;
    v.rv = rv; v.rid = rid; v.ir = ir; v.sv = sv; v.sid = sid;
    v.e_rrdy = e_rrdy; v.e_iv = e_iv; v.e_iid = e_iid; v.e_iret = e_iret;
    v.e_dv = e_dv; v.e_dok = e_dok; v.e_did = e_did; v.e_dret = e_dret; v.e_busy = e_busy;
    vq.push_back(v);
  endtask

  function automatic logic [23:0] outs();
    return {req_ready, issue_valid, issue_id, issue_retry,
            done_valid, done_ok, done_id, done_retries, busy};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    iss_cyc.delete(); iss_ret.delete();
    dn_cyc.delete(); dn_ok.delete(); dn_id.delete(); dn_ret.delete();
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_id = 8'h00; issue_ready = 1'b1;
    resp_valid = 1'b0; resp_id = 8'h00;
  endtask

  task automatic rand_inputs();
    req_valid   = 1'($urandom);
    req_id      = 8'($urandom);
    issue_ready = 1'($urandom);
    resp_valid  = 1'($urandom);
    resp_id     = 8'($urandom);
  endtask

  // Advance until a done pulse has been logged, bounded; expiry counts as a failure.
  task automatic wait_done(input string nm, input int limit);
    int k;
    k = 0;
    while (dn_cyc.size() == 0 && k < limit) begin
      tick();
      k++;
    end
    if (dn_cyc.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no done pulse within %0d cycles", nm, limit);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int a;
  int b;

  initial begin
    // Reset held for two cycles with random inputs.
    reset = 1'b1;
    rand_inputs();
    tick();
    rand_inputs();
    @(negedge clk);
    chk("rst_req_ready_during_reset", req_ready, 1'b0);
    tick();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("rst_outputs_after_reset", outs(), {1'b1, 23'b0});
    tick();

    // Success with response at timer=3 (mismatches ignored), then minimum turnaround
    // with a response offered during ISSUE (ignored) and again in the first WAIT cycle.
    //   rv rid    ir sv sid   | rrdy iv iid   iret dv dok did   dret busy
    addv(1, 8'h5A, 1, 0, 8'h00,  1,   0, 8'h00, 0,  0, 0, 8'h00, 0,   0);
    addv(0, 8'h00, 1, 0, 8'h00,  0,   1, 8'h5A, 0,  0, 0, 8'h00, 0,   1);
    addv(0, 8'h00, 1, 0, 8'h00,  0,   0, 8'h00, 0,  0, 0, 8'h00, 0,   1);
    addv(0, 8'h00, 1, 1, 8'h5B,  0,   0, 8'h00, 0,  0, 0, 8'h00, 0,   1);
    addv(0, 8'h00, 1, 1, 8'hA5,  0,   0, 8'h00, 0,  0, 0, 8'h00, 0,   1);
    addv(0, 8'h00, 1, 1, 8'h5A,  0,   0, 8'h00, 0,  0, 0, 8'h00, 0,   1);
    addv(0, 8'h00, 1, 0, 8'h00,  0,   0, 8'h00, 0,  1, 1, 8'h5A, 0,   1);
    addv(1, 8'hA5, 1, 0, 8'h00,  1,   0, 8'h00, 0,  0, 0, 8'h00, 0,   0);
    addv(0, 8'h00, 1, 1, 8'hA5,  0,   1, 8'hA5, 0,  0, 0, 8'h00, 0,   1);
    addv(0, 8'h00, 1, 1, 8'hA5,  0,   0, 8'h00, 0,  0, 0, 8'h00, 0,   1);
    addv(0, 8'h00, 1, 0, 8'h00,  0,   0, 8'h00, 0,  1, 1, 8'hA5, 0,   1);
    addv(0, 8'h00, 1, 0, 8'h00,  1,   0, 8'h00, 0,  0, 0, 8'h00, 0,   0);

    for (int i = 0; i < vq.size(); i++) begin
      req_valid = vq[i].rv; req_id = vq[i].rid; issue_ready = vq[i].ir;
      resp_valid = vq[i].sv; resp_id = vq[i].sid;
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(),
          {vq[i].e_rrdy, vq[i].e_iv, vq[i].e_iid, vq[i].e_iret, vq[i].e_dv,
           vq[i].e_dok, vq[i].e_did, vq[i].e_dret, vq[i].e_busy});
      tick();
    end
    idle_inputs();

    // Exhaustion: three issues, eight WAIT cycles each, then a failed completion.
    clear_log();
    req_valid = 1'b1; req_id = 8'h11; issue_ready = 1'b1;
    a = cyc;
    tick();
    req_valid = 1'b0;
    wait_done("exh_done", 60);
    chk("exh_issue_count", iss_cyc.size(), 3);
    chk("exh_issue0_cyc", qget(iss_cyc, 0) - a, 1);
    chk("exh_issue1_cyc", qget(iss_cyc, 1) - a, 10);
    chk("exh_issue2_cyc", qget(iss_cyc, 2) - a, 19);
    chk("exh_retry_flags", {qget(iss_ret, 0), qget(iss_ret, 1), qget(iss_ret, 2)} & 96'h1_00000001_00000001, {32'd0, 32'd1, 32'd1});
    chk("exh_done_cyc", qget(dn_cyc, 0) - a, 28);
    chk("exh_done_ok", qget(dn_ok, 0), 0);
    chk("exh_done_id", qget(dn_id, 0), 8'h11);
    chk("exh_done_retries", qget(dn_ret, 0), 2);
    @(negedge clk);
    chk("exh_ready_after", {req_ready, busy}, 2'b10);
    tick();

    // Matching response coincident with the second attempt's timeout wins.
    clear_log();
    req_valid = 1'b1; req_id = 8'h22;
    a = cyc;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 17; k++) tick();
    resp_valid = 1'b1; resp_id = 8'h22;
    tick();
    resp_valid = 1'b0; resp_id = 8'h00;
    wait_done("sim_done", 10);
    for (int k = 0; k < 12; k++) tick();
    chk("sim_issue_count", iss_cyc.size(), 2);
    chk("sim_done_count", dn_cyc.size(), 1);
    chk("sim_done_cyc", qget(dn_cyc, 0) - a, 19);
    chk("sim_done_ok", qget(dn_ok, 0), 1);
    chk("sim_done_retries", qget(dn_ret, 0), 1);

    // Issue stall for five cycles, then a mismatched response that must not disturb the timeout.
    clear_log();
    req_valid = 1'b1; req_id = 8'h11; issue_ready = 1'b0;
    a = cyc;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall_hold%0d", k), {issue_valid, issue_id, busy}, {1'b1, 8'h11, 1'b1});
      tick();
    end
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    resp_valid = 1'b1; resp_id = 8'h12;
    tick();
    resp_valid = 1'b0; resp_id = 8'h00;
    wait_done("stall_done", 60);
    chk("stall_issue_count", iss_cyc.size(), 3);
    chk("stall_issue0_cyc", qget(iss_cyc, 0) - a, 6);
    chk("stall_issue1_cyc", qget(iss_cyc, 1) - a, 15);
    chk("stall_issue2_cyc", qget(iss_cyc, 2) - a, 24);
    chk("stall_done_cyc", qget(dn_cyc, 0) - a, 33);
    chk("stall_done_ok", qget(dn_ok, 0), 0);
    chk("stall_done_retries", qget(dn_ret, 0), 2);
    tick();

    // Reset while waiting at timer=4 aborts silently; the next request runs clean.
    clear_log();
    req_valid = 1'b1; req_id = 8'h44;
    a = cyc;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rstw_ready_low", req_ready, 1'b0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rstw_idle_after", {req_ready, busy, issue_valid, done_valid}, 4'b1000);
    for (int k = 0; k < 20; k++) tick();
    chk("rstw_no_done", dn_cyc.size(), 0);
    chk("rstw_issue_count", iss_cyc.size(), 1);
    req_valid = 1'b1; req_id = 8'h77;
    b = cyc;
    tick();
    req_valid = 1'b0;
    tick();
    resp_valid = 1'b1; resp_id = 8'h77;
    tick();
    resp_valid = 1'b0; resp_id = 8'h00;
    wait_done("rstw_new_done", 10);
    chk("rstw_new_done_cyc", qget(dn_cyc, 0) - b, 3);
    chk("rstw_new_ok", qget(dn_ok, 0), 1);
    chk("rstw_new_id", qget(dn_id, 0), 8'h77);
    chk("rstw_new_retries", qget(dn_ret, 0), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/request_retry_ctrl.md
# request_retry_ctrl

Per-request timeout and retry controller for the load balancer's dispatch path. It accepts one request at a time and issues it downstream. It then waits for a matching response under a saturating cycle timer of the same width and terminal-count rule as the team's `upcounter`. On timeout it re-issues the request up to `MAX_RETRIES` times, then reports a single pass/fail completion upstream.

## Interface

**Clocking:** one clock; reset is synchronous and active-high.

**Parameters**
- `TIMEOUT_BITS`, default 3. Timer width. Timeout fires when the timer reaches 2**TIMEOUT_BITS-1.
- `MAX_RETRIES`, default 3. Re-issues allowed after the first issue. 0 is legal.
- `ID_WIDTH`, default 8. Width of the request tag.
- `RETRY_W`, derived as max(1, $clog2(MAX_RETRIES+1)). Not user-set.

**Ports**
- `clk`, input, 1: clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `req_valid`, input, 1: a new request is offered.
- `req_ready`, output, 1: the block can accept a request.
- `req_id`, input, ID_WIDTH: tag of the offered request.
- `issue_valid`, output, 1: request is presented downstream.
- `issue_ready`, input, 1: downstream accepts the issue.
- `issue_id`, output, ID_WIDTH: latched tag.
- `issue_retry`, output, 1: set when this issue is a re-issue.
- `resp_valid`, input, 1: a response strobe.
- `resp_id`, input, ID_WIDTH: tag of the response.
- `done_valid`, output, 1: one-cycle completion pulse. There is no backpressure.
- `done_ok`, output, 1: 1 means a matching response arrived; 0 means retries were exhausted.
- `done_id`, output, ID_WIDTH: completed tag.
- `done_retries`, output, RETRY_W: number of re-issues performed.
- `busy`, output, 1: high when the state is not IDLE.

## Operation

**States:** IDLE, ISSUE, WAIT, DONE.

- **IDLE**
  - `req_ready`=1.
  - When `req_valid`=1, latch `req_id`, clear the retry count to 0, and go to ISSUE.
- **ISSUE**
  - `issue_valid`=1, `issue_id`=latched tag, `issue_retry`=(retry count != 0).
  - When `issue_ready`=1, clear the timer to 0 and go to WAIT.
  - Otherwise hold. The timer stays frozen at 0.
  - `resp_valid` is ignored in this state.
- **WAIT**
  - The timer increments by 1 each cycle.
  - The timeout condition is timer == 2**TIMEOUT_BITS-1.
  - Priority, highest first:
    1. `resp_valid`=1 and `resp_id` matches the latched tag: go to DONE with ok=1.
    2. Timeout and retry count == MAX_RETRIES: go to DONE with ok=0.
    3. Timeout otherwise: increment the retry count and go to ISSUE.
  - A non-matching response is ignored and has no effect on the timer.
  - The timer never wraps. It is cleared only on entry to WAIT.
- **DONE**
  - `done_valid`=1 for exactly one cycle.
  - `done_id`=latched tag, `done_ok` per the exit cause above, `done_retries`=retry count.
  - Next state is always IDLE.

**Arithmetic:**
- The retry count never exceeds MAX_RETRIES.
- The timer is unsigned, TIMEOUT_BITS wide, and saturating by construction, since it exits WAIT at the maximum value.

**Outputs:**
- `issue_*` are driven only while in ISSUE; they are 0 otherwise.
- `done_*` are meaningful only while `done_valid`=1 and are 0 otherwise.
- `req_ready` = (state == IDLE) and not `reset`.

**Reset:**
- State goes to IDLE; the timer, retry count and latched tag go to 0.
- All outputs are 0 except `req_ready`, which is 1 from the first cycle after `reset` deasserts.
- A reset in any state aborts the request with no `done_valid` pulse.

## Timing

- Accept in cycle t: `issue_valid` is first high in t+1.
- Issue handshake in cycle u: WAIT begins at u+1 with timer=0.
  - A timeout is detected in cycle u+2**TIMEOUT_BITS, which is the WAIT cycle with timer=max.
  - The re-issue appears one cycle later.
- Matching response in WAIT cycle w: `done_valid` is high in w+1, and `req_ready` is high in w+2.
- Minimum request turnaround, with a response in the first WAIT cycle and `issue_ready` tied high, is 4 cycles from accept to `req_ready`.
- Total WAIT cycles for a full failure = (MAX_RETRIES+1) × 2**TIMEOUT_BITS.
- A response simultaneous with the timeout counts as success.

## Test plan

All scenarios use TIMEOUT_BITS=3, MAX_RETRIES=2, ID_WIDTH=8.

1. **Reset:** assert `reset` for 2 cycles with random inputs. Then `req_ready`=1, `busy`=0, and all other outputs are 0.
2. **Normal success:** request id 0x5A with `issue_ready`=1, then a matching response when timer=3. Exactly one `done_valid` with ok=1, id=0x5A, retries=0, and a single issue with `issue_retry`=0.
3. **Exhaustion:** request id 0x11 with no response. There are 3 issues with `issue_retry`=0,1,1, each followed by 8 WAIT cycles. Then `done_valid` with ok=0 and retries=2.
4. **Simultaneous response and timeout:** a matching response in the WAIT cycle where timer=7 on the second attempt. Result is ok=1 and retries=1, with no third issue.
5. **Stall and mismatch:** hold `issue_ready`=0 for 5 cycles. `issue_valid` stays high with a stable id and `busy`=1. Then send a response with id 0x12 against latched 0x11. It is ignored, and the timeout proceeds on schedule.
6. **Reset mid-WAIT:** assert `reset` at timer=4. No `done_valid` pulse, and the block returns to IDLE. A new request after reset completes normally with retries=0.
